acc_fifo_link: RTL and testbench
================================

// Module: acc_fifo_link
// PURPOSE
//  Accelerator-side responder for the router put/get protocol. One instance per accelerator (FFT, FIR, IIR).
//  Holds two independent FIFOs:
//  - to-acc: filled by router put_req, drained by accelerator rd_req.
//  - from-acc: filled by accelerator wr_req, drained by router get_req.
//  Drives the empty/full flags that the router uses to pause address generation.
// PARAMETERS
//  DATA_W  32  data word width, both FIFOs
//  DEPTH   16  entries per FIFO; power of two, >=2
//  ADDR_W  4   log2(DEPTH); pointer width (count width is ADDR_W+1)
// PORTS
//  clk        in   1       system clock; all state updates on rising edge
//  reset      in   1       asynchronous, active-low reset
//  clear      in   1       sync flush of both FIFOs (router drops acc enable)
//  put_req    in   1       router writes put_data into to-acc FIFO
//  put_data   in   DATA_W  router write data
//  get_req    in   1       router pops from-acc FIFO
//  get_data   out  DATA_W  registered head of from-acc FIFO
//  to_empty   out  1       to-acc FIFO count==0
//  to_full    out  1       to-acc FIFO count==DEPTH
//  from_empty out  1       from-acc FIFO count==0
//  from_full  out  1       from-acc FIFO count==DEPTH
//  acc_rd_req in   1       accelerator pops to-acc FIFO
//  acc_rd_data out DATA_W  registered head of to-acc FIFO
//  acc_rd_vld out  1       high 1 cycle when acc_rd_data updated by accepted pop
//  acc_wr_req in   1       accelerator pushes acc_wr_data into from-acc FIFO
//  acc_wr_data in  DATA_W  accelerator write data
// BEHAVIOUR
//  - Reset (reset=0, async):
//    - pointers and counts = 0
//    - get_data, acc_rd_data = 0; acc_rd_vld = 0
//    - to_empty = from_empty = 1; to_full = from_full = 0
//    - reset mid-burst discards all contents
//  - Flags: combinational decode of the registered count only; they never depend on same-cycle requests.
//  - Push (put_req / acc_wr_req):
//    - accepted iff !full at the clock edge
//    - write at wr_ptr; wr_ptr += 1 (wraps DEPTH-1 -> 0); count += 1
//    - push on full is dropped; no state change
//  - Pop (get_req / acc_rd_req):
//    - accepted iff !empty at the clock edge
//    - mem[rd_ptr] registered onto the data output; rd_ptr += 1 with wrap; count -= 1
//    - latency: request at edge N, data valid after edge N+1
//    - data output holds its last value when no pop is accepted
//    - pop on empty is dropped; output holds; acc_rd_vld = 0
//  - Simultaneous push and pop, same FIFO:
//    - both accepted if the flags allow; count unchanged
//    - on full: pop accepted, push rejected (no write-through)
//    - on empty: push accepted, pop rejected (no bypass; data visible after the next pop)
//  - The two FIFOs are fully independent; all four requests may be asserted in one cycle.
//  - clear=1 (sync):
//    - pointers/counts -> 0; acc_rd_vld -> 0; data outputs hold
//    - clear has priority over every request that cycle
// CONFIGURATION
//  - FIFO_ERR_FLAGS_EN defined:
//    - extra outputs err_ovf and err_udf, 1 bit each, sticky
//    - err_ovf set by any push on full; err_udf set by any pop on empty (either FIFO)
//    - both cleared by reset or clear; set takes effect the cycle after the illegal request
//  - Not defined: these ports are absent; illegal requests are silently dropped as above.
// TESTING
//  - Reset:
//    - reset=0 mid-stream with 5 entries queued -> to_empty=1, to_full=0, acc_rd_data=0 asynchronously
//  - Fill to-acc FIFO:
//    - 16 puts of 0x100..0x10F -> to_full=1 after 16th edge
//    - 17th put 0x1FF dropped
//    - 16 acc_rd_req -> 0x100..0x10F in order, 1-cycle latency; then to_empty=1
//  - Wrap-around:
//    - put 10, pop 10, put 12 (pointers wrap), pop 12 -> FIFO order preserved, no lost or duplicated word
//  - Simultaneous ops on from-acc FIFO:
//    - at count=16, acc_wr_req+get_req -> count 15, write dropped
//    - at count=0, both -> count 1, get_data unchanged
//    - at count=8, both -> count stays 8
//  - Underflow / clear:
//    - get_req on empty -> get_data holds; err_udf=1 if FIFO_ERR_FLAGS_EN
//    - clear with 7 entries queued -> from_empty=1 next cycle, err flags 0
//  - Independence:
//    - all four requests every cycle for 64 cycles with random data -> each FIFO matches its scoreboard model

Source files
------------

// File: rtl/acc_fifo_link.sv
// Accelerator-side put/get responder: to-acc and from-acc FIFOs with flags.
// Optional sticky error outputs err_ovf/err_udf under `FIFO_ERR_FLAGS_EN.
module acc_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full
);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              push_ok, pop_ok, wr_en;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign pop_data = dout_q;

  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_en    = push_ok & ~clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        dout_d   = mem_q[rd_ptr_q];
      end
      if (push_ok && !pop_ok) cnt_d = cnt_q + CNT_ONE;
      if (pop_ok && !push_ok) cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end
endmodule

module acc_fifo_link #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              put_req,
  input  logic [DATA_W-1:0] put_data,
  input  logic              get_req,
  output logic [DATA_W-1:0] get_data,
  output logic              to_empty,
  output logic              to_full,
  output logic              from_empty,
  output logic              from_full,
  input  logic              acc_rd_req,
  output logic [DATA_W-1:0] acc_rd_data,
  output logic              acc_rd_vld,
  input  logic              acc_wr_req,
  input  logic [DATA_W-1:0] acc_wr_data
`ifdef FIFO_ERR_FLAGS_EN
  ,output logic             err_ovf
  ,output logic             err_udf
`endif
);
  logic acc_rd_vld_q, acc_rd_vld_d;

  acc_fifo_mem #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) u_to (
    .clk(clk), .reset(reset), .clear(clear),
    .push(put_req), .push_data(put_data),
    .pop(acc_rd_req), .pop_data(acc_rd_data),
    .empty(to_empty), .full(to_full)
  );

  acc_fifo_mem #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) u_from (
    .clk(clk), .reset(reset), .clear(clear),
    .push(acc_wr_req), .push_data(acc_wr_data),
    .pop(get_req), .pop_data(get_data),
    .empty(from_empty), .full(from_full)
  );

  assign acc_rd_vld = acc_rd_vld_q;

  always_comb begin
    acc_rd_vld_d = ~clear & acc_rd_req & ~to_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_rd_vld_q <= 1'b0;
    else        acc_rd_vld_q <= acc_rd_vld_d;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

  always_comb begin
    err_ovf_d = err_ovf_q | (put_req & to_full)
                          | (acc_wr_req & from_full);
    err_udf_d = err_udf_q | (acc_rd_req & to_empty)
                          | (get_req & from_empty);
    if (clear) begin
      err_ovf_d = 1'b0;
      err_udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end
`endif
endmodule

// File: tb/tb_acc_fifo_link.sv
// Bench for acc_fifo_link: vector table, directed corners, random vs queue model.
// Error-flag checks follow FIFO_ERR_FLAGS_EN when defined.
module tb_acc_fifo_link;
  logic        clk = 1'b0;
  logic        reset;
  logic        clear, put_req, get_req, acc_rd_req, acc_wr_req;
  logic [31:0] put_data, acc_wr_data, get_data, acc_rd_data;
  logic        to_empty, to_full, from_empty, from_full, acc_rd_vld;
`ifdef FIFO_ERR_FLAGS_EN
  logic        err_ovf, err_udf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] tq[$];
  logic [31:0] fq[$];
  logic [31:0] m_gd, m_ad;
  logic        m_vld, m_ovf, m_udf;

  always #5 clk = ~clk;

  acc_fifo_link #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .put_req(put_req), .put_data(put_data),
    .get_req(get_req), .get_data(get_data),
    .to_empty(to_empty), .to_full(to_full),
    .from_empty(from_empty), .from_full(from_full),
    .acc_rd_req(acc_rd_req), .acc_rd_data(acc_rd_data),
    .acc_rd_vld(acc_rd_vld),
    .acc_wr_req(acc_wr_req), .acc_wr_data(acc_wr_data)
`ifdef FIFO_ERR_FLAGS_EN
    ,.err_ovf(err_ovf), .err_udf(err_udf)
`endif
  );

  typedef struct {
    logic c, p; logic [31:0] pd;
    logic g, r, w; logic [31:0] wd;
    logic te, tf, fe, ff;
    logic [31:0] gd, ad;
    logic vld;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tq.delete(); fq.delete();
    m_gd = '0; m_ad = '0; m_vld = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic check_all();
    chk("to_empty",   32'(to_empty),   32'(tq.size() == 0));
    chk("to_full",    32'(to_full),    32'(tq.size() == 16));
    chk("from_empty", 32'(from_empty), 32'(fq.size() == 0));
    chk("from_full",  32'(from_full),  32'(fq.size() == 16));
    chk("get_data",   get_data,        m_gd);
    chk("acc_rd_data", acc_rd_data,    m_ad);
    chk("acc_rd_vld", 32'(acc_rd_vld), 32'(m_vld));
`ifdef FIFO_ERR_FLAGS_EN
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
    chk("err_udf", 32'(err_udf), 32'(m_udf));
`endif
  endtask

  // One clock: drive, advance the queue model, step past the edge, compare.
  task automatic cyc(input logic c, input logic p, input logic [31:0] pd,
                     input logic g, input logic r, input logic w,
                     input logic [31:0] wd);
    int ts, fs;
    clear = c; put_req = p; put_data = pd;
    get_req = g; acc_rd_req = r; acc_wr_req = w; acc_wr_data = wd;
    ts = tq.size(); fs = fq.size();
    if (c) begin
      tq.delete(); fq.delete();
      m_vld = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_vld = 0;
      if (r) begin
        if (ts > 0) begin m_ad = tq.pop_front(); m_vld = 1; end
        else m_udf = 1;
      end
      if (g) begin
        if (fs > 0) m_gd = fq.pop_front();
        else m_udf = 1;
      end
      if (p) begin
        if (ts < 16) tq.push_back(pd);
        else m_ovf = 1;
      end
      if (w) begin
        if (fs < 16) fq.push_back(wd);
        else m_ovf = 1;
      end
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic put(input logic [31:0] d); cyc(0,1,d,0,0,0,0); endtask
  task automatic wr(input logic [31:0] d);  cyc(0,0,0,0,0,1,d); endtask
  task automatic rd();  cyc(0,0,0,0,1,0,0); endtask
  task automatic get(); cyc(0,0,0,1,0,0,0); endtask

  vec_t vt[8];

  initial begin
    reset = 0; clear = 0; put_req = 0; get_req = 0;
    acc_rd_req = 0; acc_wr_req = 0; put_data = 0; acc_wr_data = 0;
    model_reset();
    #12;
    check_all();
    reset = 1;

    //        c p pd     g r w wd     te tf fe ff gd     ad     vld
    vt[0] = '{0,1,32'hA1,0,0,0,32'h0, 0,0,1,0,32'h0, 32'h0, 0};
    vt[1] = '{0,0,32'h0, 0,1,0,32'h0, 1,0,1,0,32'h0, 32'hA1,1};
    vt[2] = '{0,0,32'h0, 0,1,0,32'h0, 1,0,1,0,32'h0, 32'hA1,0};
    vt[3] = '{0,0,32'h0, 1,0,1,32'hB2,1,0,0,0,32'h0, 32'hA1,0};
    vt[4] = '{0,0,32'h0, 1,0,0,32'h0, 1,0,1,0,32'hB2,32'hA1,0};
    vt[5] = '{0,1,32'hC3,0,0,1,32'hD4,0,0,0,0,32'hB2,32'hA1,0};
    vt[6] = '{1,1,32'hE5,1,1,1,32'hF6,1,0,1,0,32'hB2,32'hA1,0};
    vt[7] = '{0,0,32'h0, 0,1,0,32'h0, 1,0,1,0,32'hB2,32'hA1,0};
    for (int i = 0; i < 8; i++) begin
      cyc(vt[i].c, vt[i].p, vt[i].pd, vt[i].g, vt[i].r, vt[i].w, vt[i].wd);
      chk($sformatf("vec%0d.te", i),  32'(to_empty),   32'(vt[i].te));
      chk($sformatf("vec%0d.tf", i),  32'(to_full),    32'(vt[i].tf));
      chk($sformatf("vec%0d.fe", i),  32'(from_empty), 32'(vt[i].fe));
      chk($sformatf("vec%0d.ff", i),  32'(from_full),  32'(vt[i].ff));
      chk($sformatf("vec%0d.gd", i),  get_data,        vt[i].gd);
      chk($sformatf("vec%0d.ad", i),  acc_rd_data,     vt[i].ad);
      chk($sformatf("vec%0d.vld", i), 32'(acc_rd_vld), 32'(vt[i].vld));
    end
    cyc(1,0,0,0,0,0,0);

    // fill to-acc, overflow, drain in order
    for (int i = 0; i < 16; i++) put(32'h100 + i);
    chk("fill.to_full", 32'(to_full), 32'd1);
    put(32'h1FF);
    chk("ovf.to_full", 32'(to_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("drain.data", acc_rd_data, 32'h100 + i);
      chk("drain.vld", 32'(acc_rd_vld), 32'd1);
    end
    chk("drain.to_empty", 32'(to_empty), 32'd1);

    // wrap-around
    for (int i = 0; i < 10; i++) put(32'h500 + i);
    for (int i = 0; i < 10; i++) begin
      rd(); chk("wrap1.data", acc_rd_data, 32'h500 + i);
    end
    for (int i = 0; i < 12; i++) put(32'h600 + i);
    for (int i = 0; i < 12; i++) begin
      rd(); chk("wrap2.data", acc_rd_data, 32'h600 + i);
    end
    chk("wrap.to_empty", 32'(to_empty), 32'd1);

    // from-acc simultaneous push/pop at full, empty, half
    for (int i = 0; i < 16; i++) wr(32'h200 + i);
    chk("f.from_full", 32'(from_full), 32'd1);
    cyc(0,0,0,1,0,1,32'h2FF);
    chk("full_both.gd", get_data, 32'h200);
    chk("full_both.ff", 32'(from_full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      get(); chk("full_both.drain", get_data, 32'h200 + i);
    end
    chk("full_both.fe", 32'(from_empty), 32'd1);
    cyc(0,0,0,1,0,1,32'h300);
    chk("empty_both.gd", get_data, 32'h20F);
    chk("empty_both.fe", 32'(from_empty), 32'd0);
    get();
    chk("empty_both.pop", get_data, 32'h300);
    for (int i = 0; i < 8; i++) wr(32'h400 + i);
    cyc(0,0,0,1,0,1,32'h4AA);
    chk("half_both.gd", get_data, 32'h400);
    for (int i = 1; i < 8; i++) begin
      get(); chk("half_both.drain", get_data, 32'h400 + i);
    end
    get();
    chk("half_both.last", get_data, 32'h4AA);
    chk("half_both.fe", 32'(from_empty), 32'd1);

    // underflow and clear
    get();
    chk("udf.gd_hold", get_data, 32'h4AA);
    for (int i = 0; i < 7; i++) wr(32'h700 + i);
    cyc(1,0,0,0,0,0,0);
    chk("clear.fe", 32'(from_empty), 32'd1);
    chk("clear.gd_hold", get_data, 32'h4AA);

    // all four requests each cycle, then random requests
    for (int i = 0; i < 64; i++)
      cyc(0,1,$urandom,1,1,1,$urandom);
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0,40) == 0), 1'($urandom), $urandom,
          1'($urandom), 1'($urandom), 1'($urandom), $urandom);

    // asynchronous reset with 5 entries queued
    cyc(1,0,0,0,0,0,0);
    for (int i = 0; i < 6; i++) put(32'h800 + i);
    rd();
    chk("pre_rst.ad", acc_rd_data, 32'h800);
    #2 reset = 0;
    #1;
    chk("arst.to_empty", 32'(to_empty), 32'd1);
    chk("arst.to_full", 32'(to_full), 32'd0);
    chk("arst.ad", acc_rd_data, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1;
    check_all();
    rd();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
